lcd_cmd_driver: RTL and testbench
=================================

# lcd_cmd_driver

Peripheral-side driver for the character LCD register written by the core's memory-mapped IO path. It accepts one command or data byte per valid/ready handshake and generates the HD44780-style bus timing for each byte: RS/data setup, enable pulse, hold, and execution wait. After reset it runs a fixed power-up and initialisation sequence on its own, so software only sends display traffic. It sits between the core's LCD output register and the board LCD pins.

## Interface

Parameters (all in clk_i cycles):
- T_PWRUP, 750000, wait after reset before the first init command (15 ms at 50 MHz)
- T_SETUP, 2, cycles RS/data are stable with EN low before the EN rising edge
- T_EN_HIGH, 12, EN high width
- T_HOLD, 2, cycles RS/data are held with EN low after the EN falling edge
- T_EXEC, 2000, execution wait for normal commands and data (40 µs)
- T_CLEAR, 82000, execution wait for clear/home commands (1.64 ms)

Ports:
- clk_i, input, 1, single clock
- rst_i, input, 1, asynchronous, active-high reset
- cmd_valid_i, input, 1, request strobe for a byte transfer
- cmd_rs_i, input, 1, 0 = instruction, 1 = data
- cmd_data_i, input, 8, byte to transfer
- cmd_ready_o, output, 1, driver can accept a byte
- init_done_o, output, 1, init sequence finished; stays high until reset
- busy_o, output, 1, equals the inverse of cmd_ready_o
- lcd_on_o, output, 1, LCD power/backlight enable
- lcd_en_o, output, 1, LCD enable strobe
- lcd_rs_o, output, 1, LCD register select
- lcd_rw_o, output, 1, LCD read/write select; constant 0 (write-only)
- lcd_data_o, output, 8, LCD data bus

## Operation

- States: PWRUP, INIT_LOAD, SETUP, EN_HI, HOLD, EXEC, IDLE.
- A single down-counter sized by $clog2 of the largest parameter times each state. Each timed state lasts exactly its parameter in cycles.
- **PWRUP:** lasts T_PWRUP cycles, then goes to INIT_LOAD.
- **INIT_LOAD:** lasts 1 cycle. It loads init ROM entry idx, with RS=0, then goes to SETUP.
  - ROM order: 0x38, 0x0C, 0x01, 0x06.
  - The idx counter is 2 bits.
- **IDLE:** cmd_ready_o=1 only here.
  - When cmd_valid_i && cmd_ready_o, the driver captures cmd_rs_i and cmd_data_i into output registers and goes to SETUP.
  - Inputs are ignored in every other state; there is no queueing.
- **SETUP:** EN=0, then go to EN_HI.
- **EN_HI:** EN=1, then go to HOLD.
- **HOLD:** EN=0, then go to EXEC.
- **EXEC:** the wait is T_CLEAR when RS=0 and data[7:2]==0 and data!=0 (clear and home commands); otherwise it is T_EXEC.
- **End of EXEC:**
  - If init is active and idx<3: increment idx and go to INIT_LOAD.
  - If init is active and idx==3: set init_done_o and go to IDLE.
  - Otherwise: go to IDLE.
- lcd_rs_o and lcd_data_o hold their captured value from capture until the next capture, including while in IDLE.
- lcd_on_o goes to 1 on the first clock edge after rst_i deasserts and stays 1.

## Timing

- **Reset values** (rst_i high, applied immediately and asynchronously):
  - State is PWRUP with the counter loaded and idx=0.
  - cmd_ready_o=0, busy_o=1, init_done_o=0, lcd_on_o=0, lcd_en_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_data_o=0x00.
- **Reset mid-transfer:** EN drops to 0 immediately, the transfer is abandoned, and the full power-up and init sequence reruns.
- **Handshake:**
  - Acceptance happens at clock edge k (valid and ready both high).
  - cmd_ready_o is low from cycle k+1.
  - lcd_data_o and lcd_rs_o are valid from cycle k+1.
  - lcd_en_o is high during cycles k+1+T_SETUP through k+T_SETUP+T_EN_HIGH.
- **Ready period:** cmd_ready_o is low for exactly T_SETUP+T_EN_HIGH+T_HOLD+Twait cycles, where Twait is T_EXEC or T_CLEAR. cmd_ready_o rises in the following cycle.
- **Back-to-back:** a valid held high at that rising edge is accepted in the same cycle, so ready is high for 1 cycle between transfers.
- **Init duration:** init_done_o rises T_PWRUP + 4 + 4·(T_SETUP+T_EN_HIGH+T_HOLD) + 3·T_EXEC + T_CLEAR cycles after reset release. cmd_ready_o rises in the same cycle.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use sim parameters T_PWRUP=20, T_SETUP=2, T_EN_HIGH=4, T_HOLD=2, T_EXEC=10, T_CLEAR=30.

- **Reset and init:** release rst_i.
  - The LCD bus shows exactly 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06, each 4 cycles wide with RS=0.
  - init_done_o and cmd_ready_o rise at cycle 20+4+32+30+30=116.
- **Data write:** after init, send valid with rs=1, data=0x41 for 1 cycle.
  - Data 0x41 with RS=1 appears on the next cycle.
  - EN is high during cycles +3 to +6.
  - cmd_ready_o is low for 18 cycles.
- **Clear command:** send rs=0, data=0x01. cmd_ready_o is low for 38 cycles. Repeat with 0x02 and get the same result; with 0x80 it is low for 18 cycles.
- **Back-to-back:** hold cmd_valid_i high and change data from 0x48 to 0x49 on each acceptance.
  - Ready is high for exactly 1 cycle between transfers.
  - The bytes appear in order.
- **Ignored request:** assert valid during PWRUP and during EXEC.
  - No EN pulse is produced.
  - lcd_data_o is unchanged.
- **Mid-op reset:** assert rst_i while EN is high.
  - lcd_en_o drops in the same cycle.
  - All outputs take their reset values.
  - After release, the init sequence reruns in full.

Source files
------------

// File: rtl/lcd_cmd_driver.sv
// HD44780-style character LCD command driver.
// Runs a fixed power-up/init sequence after reset, then accepts one byte per
// valid/ready handshake and generates setup / enable / hold / execution timing.
module lcd_cmd_driver #(
  parameter int unsigned T_PWRUP   = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EN_HIGH = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned TMax = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN_HIGH, T_HOLD)),
                                      max2(T_EXEC, T_CLEAR));
  localparam int unsigned CntW = (TMax > 1) ? $clog2(TMax) : 1;

  typedef logic [CntW-1:0] cnt_t;

  // Counter load values: a state lasting P cycles loads P-1 and leaves at zero.
  localparam cnt_t PwrupLd = cnt_t'(T_PWRUP - 1);
  localparam cnt_t SetupLd = cnt_t'(T_SETUP - 1);
  localparam cnt_t EnLd    = cnt_t'(T_EN_HIGH - 1);
  localparam cnt_t HoldLd  = cnt_t'(T_HOLD - 1);
  localparam cnt_t ExecLd  = cnt_t'(T_EXEC - 1);
  localparam cnt_t ClearLd = cnt_t'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    StPwrup,
    StInitLoad,
    StSetup,
    StEnHi,
    StHold,
    StExec,
    StIdle
  } state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       ready_q;
  logic       en_q;
  logic       on_q;
  logic [7:0] rom_byte;
  logic       exec_clear;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign exec_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

  // Init ROM: function set, display on, clear, entry mode.
  always_comb begin
    rom_byte = 8'h38;
    case (idx_q)
      2'd0:    rom_byte = 8'h38;
      2'd1:    rom_byte = 8'h0C;
      2'd2:    rom_byte = 8'h01;
      default: rom_byte = 8'h06;
    endcase
  end

  // Next-state, counter, init index and captured byte.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - cnt_t'(1);
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    case (state_q)
      StPwrup: begin
        if (cnt_zero) state_d = StInitLoad;
      end
      StInitLoad: begin
        rs_d    = 1'b0;
        data_d  = rom_byte;
        cnt_d   = SetupLd;
        state_d = StSetup;
      end
      StSetup: begin
        if (cnt_zero) begin
          cnt_d   = EnLd;
          state_d = StEnHi;
        end
      end
      StEnHi: begin
        if (cnt_zero) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          cnt_d   = exec_clear ? ClearLd : ExecLd;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_zero) begin
          if (!init_done_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            state_d = StInitLoad;
          end else begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          rs_d    = cmd_rs_i;
          data_d  = cmd_data_i;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      default: begin
        cnt_d   = PwrupLd;
        state_d = StPwrup;
      end
    endcase
  end

  // State and registered outputs; ready/en are decoded from the next state so
  // they line up with the state they describe without a combinational path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StPwrup;
      cnt_q       <= PwrupLd;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ready_q     <= (state_d == StIdle);
      en_q        <= (state_d == StEnHi);
      on_q        <= 1'b1;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign init_done_o = init_done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Self-checking bench for lcd_cmd_driver: per-cycle comparison against a
// timeline model, a table of single transfers, and hand-written corner cases.
module tb_lcd_cmd_driver;

  localparam int unsigned TP = 20;
  localparam int unsigned TS = 2;
  localparam int unsigned TE = 4;
  localparam int unsigned TH = 2;
  localparam int unsigned TX = 10;
  localparam int unsigned TC = 30;
  localparam int InitCycles = 116;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       busy;
  logic       lcd_on;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  lcd_cmd_driver #(
    .T_PWRUP  (TP),
    .T_SETUP  (TS),
    .T_EN_HIGH(TE),
    .T_HOLD   (TH),
    .T_EXEC   (TX),
    .T_CLEAR  (TC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_rs_i   (cmd_rs),
    .cmd_data_i (cmd_data),
    .cmd_ready_o(cmd_ready),
    .init_done_o(init_done),
    .busy_o     (busy),
    .lcd_on_o   (lcd_on),
    .lcd_en_o   (lcd_en),
    .lcd_rs_o   (lcd_rs),
    .lcd_rw_o   (lcd_rw),
    .lcd_data_o (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each byte (init or host) is a transfer starting at edge k
  // that keeps ready low for n cycles and drives EN for edges k+TS..k+TS+TE-1.
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         e;
  bit         m_done;
  int         m_idx;
  int         m_k;
  int         m_n;
  bit         m_have;
  logic       m_rs;
  logic [7:0] m_data;
  int         m_next_init;
  bit         m_ready;
  bit         m_en;
  bit         m_on;

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d != 8'h00 && d[7:2] == 6'd0) ? int'(TC) : int'(TX);
  endfunction

  task automatic model_reset();
    e = 0; m_done = 0; m_idx = 0; m_k = -1000; m_n = 0; m_have = 0;
    m_rs = 1'b0; m_data = 8'h00; m_next_init = TP + 1;
    m_ready = 0; m_en = 0; m_on = 0;
  endtask

  task automatic model_step(input logic v, input logic r, input logic [7:0] d);
    if (m_ready && v) begin
      m_k = e; m_n = TS + TE + TH + wait_of(r, d); m_rs = r; m_data = d; m_have = 1;
    end else if (!m_done && e == m_next_init) begin
      m_k = e; m_rs = 1'b0; m_data = rom[m_idx];
      m_n = TS + TE + TH + wait_of(1'b0, rom[m_idx]); m_have = 1;
    end
    if (!m_done && m_have && e == m_k + m_n) begin
      if (m_idx == 3) m_done = 1;
      else begin
        m_idx++;
        m_next_init = e + 1;
      end
    end
    m_ready = m_done && (e >= m_k + m_n);
    m_en    = m_have && (e >= m_k + TS) && (e <= m_k + TS + TE - 1);
    m_on    = 1;
  endtask

  function automatic logic [14:0] act_vec();
    return {cmd_ready, busy, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {m_ready, ~m_ready, m_done, m_on, m_en, m_rs, 1'b0, m_data};
  endfunction

  // One clock: model sees inputs at the edge; outputs compared on the falling edge.
  task automatic tick();
    logic       v;
    logic       r;
    logic [7:0] d;
    v = cmd_valid; r = cmd_rs; d = cmd_data;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      e++;
      model_step(v, r, d);
    end
    @(negedge clk);
    check($sformatf("cycle_outputs e=%0d", e), 32'(act_vec()), 32'(exp_vec()));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !cmd_ready; i++) tick();
    check("wait_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Runs from reset release until init_done, checking pulse contents and timing.
  task automatic run_init_check(input bit poke);
    int         pulses;
    int         cur_w;
    logic       prev_en;
    logic       rs_any;
    logic [7:0] seen [4];
    pulses = 0; cur_w = 0; prev_en = 1'b0; rs_any = 1'b0;
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    for (int i = 0; i < 400 && !init_done; i++) begin
      cmd_valid = poke && (e < int'(TP) - 1);
      cmd_rs    = 1'b1;
      cmd_data  = 8'hAA;
      tick();
      if (e == int'(TP)) check("pwrup_bus_unchanged", 32'(lcd_data), 32'h00);
      if (lcd_en && !prev_en) begin
        if (pulses < 4) seen[pulses] = lcd_data;
        rs_any |= lcd_rs;
        pulses++;
        cur_w = 0;
      end
      if (lcd_en) cur_w++;
      if (!lcd_en && prev_en) check("init_en_width", 32'(cur_w), 32'(TE));
      prev_en = lcd_en;
    end
    cmd_valid = 1'b0;
    check("init_done_cycle", 32'(e), 32'(InitCycles));
    check("init_done_high", 32'(init_done), 32'd1);
    check("init_ready_same_cycle", 32'(cmd_ready), 32'd1);
    check("init_pulse_count", 32'(pulses), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("init_byte%0d", i), 32'(seen[i]), 32'(rom[i]));
    check("init_rs_low", 32'(rs_any), 32'd0);
  endtask

  // Accept one byte and measure the ready-low period and EN pulse position.
  task automatic send_and_measure(input logic r, input logic [7:0] d, output int low_cnt,
                                  output int en_first, output int en_width,
                                  output logic [7:0] bus_d, output logic bus_rs);
    int off;
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    bus_d = lcd_data; bus_rs = lcd_rs;
    low_cnt = 0; en_first = -1; en_width = 0; off = 1;
    while (!cmd_ready && low_cnt < 300) begin
      low_cnt++;
      if (lcd_en) begin
        if (en_first < 0) en_first = off;
        en_width++;
      end
      tick();
      off++;
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_low;
    int         exp_en_first;
    int         exp_en_width;
  } vec_t;

  vec_t vec [10];

  initial begin
    int         low;
    int         enf;
    int         enw;
    logic [7:0] bd;
    logic       brs;
    int         pulses;
    logic       prev_en;
    int         na;
    int         hi_run;
    logic       acc;
    logic [7:0] got [4];

    vec[0] = '{1'b1, 8'h41, 18, 3, 4};
    vec[1] = '{1'b0, 8'h01, 38, 3, 4};
    vec[2] = '{1'b0, 8'h02, 38, 3, 4};
    vec[3] = '{1'b0, 8'h80, 18, 3, 4};
    vec[4] = '{1'b0, 8'h03, 38, 3, 4};
    vec[5] = '{1'b0, 8'h04, 18, 3, 4};
    vec[6] = '{1'b0, 8'h00, 18, 3, 4};
    vec[7] = '{1'b1, 8'h01, 18, 3, 4};
    vec[8] = '{1'b1, 8'h02, 18, 3, 4};
    vec[9] = '{1'b0, 8'hFF, 18, 3, 4};

    rst = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    model_reset();
    #1;
    check("reset_outputs", 32'(act_vec()), 32'h2000);
    repeat (3) tick();
    rst = 1'b0;

    // Power-up and init, with requests poked during PWRUP that must be ignored.
    run_init_check(1'b1);

    // Table of single transfers.
    for (int i = 0; i < 10; i++) begin
      wait_ready();
      send_and_measure(vec[i].rs, vec[i].data, low, enf, enw, bd, brs);
      check($sformatf("vec%0d_ready_low", i), 32'(low), 32'(vec[i].exp_low));
      check($sformatf("vec%0d_en_first", i), 32'(enf), 32'(vec[i].exp_en_first));
      check($sformatf("vec%0d_en_width", i), 32'(enw), 32'(vec[i].exp_en_width));
      check($sformatf("vec%0d_bus_data", i), 32'(bd), 32'(vec[i].data));
      check($sformatf("vec%0d_bus_rs", i), 32'(brs), 32'(vec[i].rs));
    end

    // Request during EXEC is ignored.
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    tick();
    cmd_valid = 1'b0;
    low = 0; pulses = 0; prev_en = 1'b0;
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      low++;
      if (lcd_en && !prev_en) pulses++;
      prev_en = lcd_en;
      if (i == 10) begin
        cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h66;
      end
      if (i == 13) cmd_valid = 1'b0;
      tick();
    end
    check("exec_ignore_ready_low", 32'(low), 32'd18);
    check("exec_ignore_pulses", 32'(pulses), 32'd1);
    check("exec_ignore_data", 32'(lcd_data), 32'h55);
    check("exec_ignore_rs", 32'(lcd_rs), 32'd1);

    // Back-to-back with valid held high.
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h48;
    na = 0; hi_run = 0;
    for (int i = 0; i < 200 && na < 4; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) begin
        got[na] = lcd_data;
        na++;
        cmd_data = cmd_data + 8'd1;
      end
      if (cmd_ready) hi_run++;
      else if (hi_run > 0) begin
        check("b2b_ready_width", 32'(hi_run), 32'd1);
        hi_run = 0;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_byte%0d", i), 32'(got[i]), 32'(8'h48 + i));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_rs    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       cmd_data = 8'($urandom_range(0, 3));
        1:       cmd_data = 8'h04;
        default: cmd_data = 8'($urandom);
      endcase
      tick();
    end
    cmd_valid = 1'b0;

    // Reset while EN is high.
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !lcd_en; i++) tick();
    check("midreset_en_seen", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_en_drop", 32'(lcd_en), 32'd0);
    check("midreset_outputs", 32'(act_vec()), 32'h2000);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    run_init_check(1'b0);

    wait_ready();
    send_and_measure(vec[0].rs, vec[0].data, low, enf, enw, bd, brs);
    check("post_reset_ready_low", 32'(low), 32'(vec[0].exp_low));
    check("post_reset_bus_data", 32'(bd), 32'(vec[0].data));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
